// File: rtl/mips_btb_port_arbiter.sv
// mips_btb_port_arbiter
//   Shares the single-ported BTB between fetch-stage lookups and EX-stage
//   target updates. Lookups win by default. Updates wait in a small FIFO and
//   are written back in cycles where fetch does not read. An update to an
//   address that is already queued replaces that entry's target. When the
//   FIFO fills, or an update has waited STARVE_LIMIT cycles, fetch is stalled
//   and the FIFO is drained down to DRAIN_LOW entries.
//
// Ports:
//   clk, rst_b          clock, asynchronous active-low reset
//   lookup_req/addr     fetch read request and PC (word address)
//   lookup_grant        read issued to the BTB this cycle (combinational)
//   fetch_stall         fetch must hold its PC while a forced drain runs
//   upd_valid/addr/     EX update request: branch PC and resolved target
//   upd_target
//   upd_ready           update accepted when upd_valid && upd_ready
//   btb_rd_en/wr_en     BTB read / write strobes (never both)
//   btb_addr            BTB address for the read or the write
//   btb_wr_data         BTB write data (0 when not writing)
//   fifo_count          number of queued updates
module mips_btb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DRAIN_LOW    = 1,
  parameter int AW           = 30
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     lookup_req,
  input  logic [AW-1:0]            lookup_addr,
  output logic                     lookup_grant,
  output logic                     fetch_stall,
  input  logic                     upd_valid,
  input  logic [AW-1:0]            upd_addr,
  input  logic [AW-1:0]            upd_target,
  output logic                     upd_ready,
  output logic                     btb_rd_en,
  output logic                     btb_wr_en,
  output logic [AW-1:0]            btb_addr,
  output logic [AW-1:0]            btb_wr_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] DRAIN_LOW_C = CW'(DRAIN_LOW);
  localparam logic [SW-1:0] STARVE_C    = SW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    addr_q_r [DEPTH];
  logic [AW-1:0]    tgt_q_r  [DEPTH];
  logic [PW-1:0]    head_r, tail_r;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic [SW-1:0]    starve_r;

  logic             empty_s;
  logic             pop_s;
  logic             accept_s;
  logic             hit_s;
  logic [PW-1:0]    hit_idx_s;
  logic             push_new_s;

  assign empty_s    = (count_r == {CW{1'b0}});
  assign upd_ready  = (count_r < DEPTH_C);
  assign accept_s   = upd_valid && upd_ready;
  // A write drains the head: always in FORCE, otherwise only when fetch is idle.
  assign pop_s      = !empty_s && ((state_r == ST_FORCE) || !lookup_req);
  assign push_new_s = accept_s && !hit_s;
  assign count_nxt_s = count_r + CW'(push_new_s) - CW'(pop_s);

  // Coalesce search over occupied slots; the head is skipped when it leaves this cycle.
  always_comb begin
    logic [PW-1:0] off_v;
    hit_s     = 1'b0;
    hit_idx_s = {PW{1'b0}};
    off_v     = {PW{1'b0}};
    for (int j = 0; j < DEPTH; j++) begin
      off_v = PW'(j) - head_r;
      if (({1'b0, off_v} < count_r) && !(pop_s && (off_v == {PW{1'b0}})) &&
          (addr_q_r[j] == upd_addr) && !hit_s) begin
        hit_s     = 1'b1;
        hit_idx_s = PW'(j);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // BTB port mux: read for fetch in NORMAL, otherwise the head write if any.
  always_comb begin
    fetch_stall  = (state_r == ST_FORCE);
    btb_rd_en    = lookup_req && (state_r == ST_NORMAL);
    lookup_grant = btb_rd_en;
    btb_wr_en    = pop_s;
    if (pop_s) begin
      btb_addr    = addr_q_r[head_r];
      btb_wr_data = tgt_q_r[head_r];
    end else begin
      btb_addr    = lookup_addr;
      btb_wr_data = {AW{1'b0}};
    end
  end

  // Drain-mode next state; entry is decided on the registered count and starve counter.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_NORMAL: begin
        if ((count_r == DEPTH_C) || (starve_r == STARVE_C)) begin
          state_nxt_s = ST_FORCE;
        end else begin
          state_nxt_s = ST_NORMAL;
        end
      end
      ST_FORCE: begin
        if (count_nxt_s <= DRAIN_LOW_C) begin
          state_nxt_s = ST_NORMAL;
        end else begin
          state_nxt_s = ST_FORCE;
        end
      end
      default: state_nxt_s = ST_NORMAL;
    endcase
  end

  // Control state: drain FSM, FIFO pointers/count and starvation counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r  <= ST_NORMAL;
      head_r   <= {PW{1'b0}};
      tail_r   <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      starve_r <= {SW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (pop_s) begin
        head_r <= head_r + 1'b1;
      end
      if (push_new_s) begin
        tail_r <= tail_r + 1'b1;
      end
      if (pop_s || empty_s) begin
        starve_r <= {SW{1'b0}};
      end else if (starve_r < STARVE_C) begin
        starve_r <= starve_r + 1'b1;
      end
    end
  end

  // Entry storage: new pushes land at the tail, coalesced updates overwrite in place.
  always_ff @(posedge clk) begin
    if (push_new_s) begin
      addr_q_r[tail_r] <= upd_addr;
      tgt_q_r[tail_r]  <= upd_target;
    end
    if (accept_s && hit_s) begin
      tgt_q_r[hit_idx_s] <= upd_target;
    end
  end

  assign fifo_count = count_r;

endmodule

// File: tb/tb_mips_btb_port_arbiter.sv
module tb_mips_btb_port_arbiter;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          lookup_req;
  logic [AW-1:0] lookup_addr;
  logic          lookup_grant;
  logic          fetch_stall;
  logic          upd_valid;
  logic [AW-1:0] upd_addr;
  logic [AW-1:0] upd_target;
  logic          upd_ready;
  logic          btb_rd_en;
  logic          btb_wr_en;
  logic [AW-1:0] btb_addr;
  logic [AW-1:0] btb_wr_data;
  logic [2:0]    fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  mips_btb_port_arbiter #(
    .DEPTH(4), .STARVE_LIMIT(8), .DRAIN_LOW(1), .AW(AW)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .lookup_req(lookup_req), .lookup_addr(lookup_addr), .lookup_grant(lookup_grant),
    .fetch_stall(fetch_stall),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_target(upd_target), .upd_ready(upd_ready),
    .btb_rd_en(btb_rd_en), .btb_wr_en(btb_wr_en), .btb_addr(btb_addr),
    .btb_wr_data(btb_wr_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0; lookup_req = 1'b0; lookup_addr = '0;
    upd_valid = 1'b0; upd_addr = '0; upd_target = '0;

    // 1. reset / idle
    #3;
    check_eq("rst_grant", lookup_grant, 64'd0);
    check_eq("rst_stall", fetch_stall, 64'd0);
    check_eq("rst_wr_en", btb_wr_en, 64'd0);
    check_eq("rst_addr",  btb_addr, 64'd0);
    check_eq("rst_ready", upd_ready, 64'd1);
    check_eq("rst_count", fifo_count, 64'd0);
    #10 rst_b = 1'b1;
    tick(); tick(); #2;
    check_eq("idle_rd_en", btb_rd_en, 64'd0);
    check_eq("idle_wdata", btb_wr_data, 64'd0);

    // 2. starvation-forced drain under continuous fetch
    tick();
    lookup_req = 1'b1; lookup_addr = 30'h0AA;
    upd_valid = 1'b1; upd_addr = 30'h100; upd_target = 30'h200; #2;
    check_eq("t2_c0_grant", lookup_grant, 64'd1);
    check_eq("t2_c0_wr_en", btb_wr_en, 64'd0);
    tick(); upd_valid = 1'b0; #2;
    check_eq("t2_c1_count", fifo_count, 64'd1);
    check_eq("t2_c1_addr", btb_addr, 64'h0AA);
    for (int c = 2; c <= 9; c++) begin
      tick(); #2;
      check_eq($sformatf("t2_c%0d_stall", c), fetch_stall, 64'd0);
      check_eq($sformatf("t2_c%0d_wr_en", c), btb_wr_en, 64'd0);
    end
    tick(); #2;
    check_eq("t2_c10_stall", fetch_stall, 64'd1);
    check_eq("t2_c10_grant", lookup_grant, 64'd0);
    check_eq("t2_c10_wr_en", btb_wr_en, 64'd1);
    check_eq("t2_c10_addr", btb_addr, 64'h100);
    check_eq("t2_c10_data", btb_wr_data, 64'h200);
    tick(); #2;
    check_eq("t2_c11_stall", fetch_stall, 64'd0);
    check_eq("t2_c11_grant", lookup_grant, 64'd1);
    check_eq("t2_c11_count", fifo_count, 64'd0);

    // 3. idle-cycle writeback, no same-cycle bypass
    tick();
    lookup_req = 1'b0;
    upd_valid = 1'b1; upd_addr = 30'h100; upd_target = 30'h200; #2;
    check_eq("t3_c0_wr_en", btb_wr_en, 64'd0);
    tick(); upd_valid = 1'b0; #2;
    check_eq("t3_c1_wr_en", btb_wr_en, 64'd1);
    check_eq("t3_c1_addr", btb_addr, 64'h100);
    check_eq("t3_c1_data", btb_wr_data, 64'h200);
    check_eq("t3_c1_rd_en", btb_rd_en, 64'd0);
    tick(); #2;
    check_eq("t3_c2_count", fifo_count, 64'd0);
    check_eq("t3_c2_wr_en", btb_wr_en, 64'd0);

    // 4. fill to DEPTH, forced drain 4 -> 1
    lookup_req = 1'b1; lookup_addr = 30'h055;
    for (int k = 0; k < 4; k++) begin
      tick();
      upd_valid = 1'b1;
      upd_addr = 30'(16 * (k + 1));
      upd_target = 30'(16 * (k + 1) + 1);
      #2;
      check_eq($sformatf("t4_c%0d_ready", k), upd_ready, 64'd1);
    end
    tick();
    upd_addr = 30'h050; upd_target = 30'h051; #2;
    check_eq("t4_c4_ready", upd_ready, 64'd0);
    check_eq("t4_c4_count", fifo_count, 64'd4);
    check_eq("t4_c4_stall", fetch_stall, 64'd0);
    tick(); upd_valid = 1'b0; #2;
    check_eq("t4_c5_stall", fetch_stall, 64'd1);
    check_eq("t4_c5_count", fifo_count, 64'd4);
    check_eq("t4_c5_addr", btb_addr, 64'h010);
    check_eq("t4_c5_data", btb_wr_data, 64'h011);
    check_eq("t4_c5_rd_en", btb_rd_en, 64'd0);
    tick(); #2;
    check_eq("t4_c6_addr", btb_addr, 64'h020);
    check_eq("t4_c6_count", fifo_count, 64'd3);
    tick(); #2;
    check_eq("t4_c7_addr", btb_addr, 64'h030);
    check_eq("t4_c7_stall", fetch_stall, 64'd1);
    tick();
    // 5. coalesce behind blocked head 0x40 (fetch still reading)
    upd_valid = 1'b1; upd_addr = 30'h100; upd_target = 30'h200; #2;
    check_eq("t4_c8_stall", fetch_stall, 64'd0);
    check_eq("t4_c8_grant", lookup_grant, 64'd1);
    check_eq("t4_c8_count", fifo_count, 64'd1);
    tick();
    upd_target = 30'h300; #2;
    check_eq("t5_c9_count", fifo_count, 64'd2);
    tick();
    upd_valid = 1'b0; lookup_req = 1'b0; #2;
    check_eq("t5_c10_count", fifo_count, 64'd2);
    check_eq("t5_c10_addr", btb_addr, 64'h040);
    check_eq("t5_c10_data", btb_wr_data, 64'h041);
    tick(); #2;
    check_eq("t5_c11_wr_en", btb_wr_en, 64'd1);
    check_eq("t5_c11_addr", btb_addr, 64'h100);
    check_eq("t5_c11_data", btb_wr_data, 64'h300);
    tick(); #2;
    check_eq("t5_c12_count", fifo_count, 64'd0);
    check_eq("t5_c12_wr_en", btb_wr_en, 64'd0);

    // 6. reset during FORCE with count 3
    lookup_req = 1'b1; lookup_addr = 30'h077;
    for (int k = 0; k < 4; k++) begin
      tick();
      upd_valid = 1'b1;
      upd_addr = 30'(4096 * (k + 1));
      upd_target = 30'(4096 * (k + 1) + 5);
    end
    tick(); upd_valid = 1'b0;
    tick(); tick(); #2;
    check_eq("t6_pre_stall", fetch_stall, 64'd1);
    check_eq("t6_pre_count", fifo_count, 64'd3);
    #1;
    rst_b = 1'b0; lookup_req = 1'b0; lookup_addr = '0;
    #1;
    check_eq("t6_rst_stall", fetch_stall, 64'd0);
    check_eq("t6_rst_wr_en", btb_wr_en, 64'd0);
    check_eq("t6_rst_count", fifo_count, 64'd0);
    check_eq("t6_rst_addr", btb_addr, 64'd0);
    check_eq("t6_rst_ready", upd_ready, 64'd1);
    #3 rst_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(); #2;
      check_eq($sformatf("t6_post%0d_wr_en", c), btb_wr_en, 64'd0);
      check_eq($sformatf("t6_post%0d_count", c), fifo_count, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_btb_port_arbiter.md
Name: mips_btb_port_arbiter

Overview:
Arbitrates the single-ported branch target buffer between two requesters: fetch-stage lookups and EX-stage BTB target updates.
- Fetch lookups have priority.
- Updates are buffered in a small FIFO and written back in idle cycles.
- Same-address updates are coalesced.
- Fetch is stalled to force a drain when the FIFO is full or an update has starved too long.
- Sits between the fetch/branch-prediction logic and the BTB storage array.

Parameters:
DEPTH, 4, update FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, cycles a non-empty FIFO may go without a write before a forced drain (>=1)
DRAIN_LOW, 1, forced drain ends once the FIFO count is <= this value (< DEPTH)
AW, 30, word address / target width

Ports:
clk  in  1  clock
rst_b  in  1  reset
lookup_req  in  1  fetch requests a BTB read this cycle
lookup_addr  in  AW  fetch PC (word address)
lookup_grant  out  1  read issued to BTB this cycle (combinational)
fetch_stall  out  1  fetch must hold its PC (forced drain active)
upd_valid  in  1  EX update request
upd_addr  in  AW  branch PC to write
upd_target  in  AW  resolved target
upd_ready  out  1  update accepted when upd_valid && upd_ready
btb_rd_en  out  1  BTB read strobe
btb_wr_en  out  1  BTB write strobe
btb_addr  out  AW  BTB index/tag address (read or write)
btb_wr_data  out  AW  BTB write data
fifo_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
Reset and clock:
- Reset rst_b, asynchronous, active-low; clock clk.
- Reset state: FIFO empty, fifo_count=0, state=NORMAL, starve_cnt=0.
- Out of reset: lookup_grant=0, fetch_stall=0, btb_rd_en=0, btb_wr_en=0, btb_addr=0, btb_wr_data=0, upd_ready=1.
- Reset mid-drain discards all queued updates; no write is issued in the reset cycle.

Update FIFO:
- upd_ready = (fifo_count < DEPTH). No bypass when full, even if a pop occurs the same cycle.
- Coalesce: an accepted update whose upd_addr matches a queued entry overwrites that entry's target; count is unchanged. The head entry is excluded from the match when it is popped in the same cycle; the update is then pushed as a new entry.
- No empty-FIFO bypass: an update accepted in cycle N is written no earlier than N+1.
- Simultaneous push and pop: count unchanged, order preserved. Pointers wrap modulo DEPTH.

States:
- NORMAL -> FORCE (registered, effective next cycle) when fifo_count==DEPTH or starve_cnt==STARVE_LIMIT.
- FORCE -> NORMAL when the post-pop count <= DRAIN_LOW.
- FORCE never reads the BTB.

Outputs (combinational from state and FIFO):
- fetch_stall = (state==FORCE).
- lookup_grant = btb_rd_en = lookup_req && state==NORMAL.
- btb_wr_en = fifo non-empty && (state==FORCE || !lookup_req). A write pops the head.
- btb_addr = head address when writing, else lookup_addr.
- btb_wr_data = head target when writing, else 0.
- Read and write are never asserted together.

starve_cnt:
- Cleared on any write or when the FIFO is empty.
- Otherwise increments each cycle, saturating at STARVE_LIMIT.

Test Plan:
1. Reset, then idle -> all outputs 0, upd_ready=1, fifo_count=0.
2. lookup_req=1 continuously; one update (addr 0x100, tgt 0x200) at cycle 0 -> count=1. Starve_cnt reaches 8; FORCE is entered the next cycle with fetch_stall=1. One write (0x100/0x200) occurs, then NORMAL resumes with lookup_grant=1.
3. lookup_req=0; update at cycle 0 -> btb_wr_en=1 at cycle 1 with addr 0x100, data 0x200; count returns to 0.
4. lookup_req=1; 4 distinct updates -> upd_ready=0 at count 4. FORCE drains 3 entries on back-to-back cycles (4->1), then NORMAL.
5. Queue 0x100->0x200 behind a blocked head, then send 0x100->0x300 -> count unchanged; the later write carries 0x300.
6. Assert rst_b=0 during FORCE with count=3 -> outputs clear immediately; after release count=0 and no stale write occurs.
